pipeline_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage RV32I pipeline. Drives the IF_ID register
//  (write_enable, flush_jal, flush_branch), the PC enable and the ID_EX bubble.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller operating states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  // Encoding of "addi x0, x0, 0", the instruction a bubble stands for.
  localparam logic [31:0] NOP = 32'h00000013;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: fixed-priority
// arbitration of HALT, dmem wait, taken branch, load-use and jump, with a
// dmem wait watchdog and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             id_jal,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             flush_jal,
  output logic             flush_branch,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = cnt_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic mem_busy;

  // Hazard detection on the raw pipeline inputs.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    mem_busy = dmem_req && !dmem_ready;
  end

  // Next-state, wait counter and priority-arbitrated control outputs.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    timeout_d    = timeout_q;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    flush_jal    = 1'b0;
    flush_branch = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;

    if (reset) begin
      // Keep the front end idle and feed NOPs while reset is held.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state_q == HALT) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
    end else if (mem_busy) begin
      // Whole pipeline holds; any pending branch/jump is re-evaluated later.
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
      if (state_q == RUN) begin
        state_d = MEM_WAIT;
      end else if (wait_q == WAIT_LAST) begin
        state_d   = HALT;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      state_d = RUN;
      if (ex_br_taken) begin
        if_id_we     = 1'b0;
        flush_branch = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        // The jump, if any, is taken once the load result is available.
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (id_jal) begin
        if_id_we  = 1'b0;
        flush_jal = 1'b1;
      end
    end
  end

  // FSM state, consecutive-wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_we),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_jal || flush_branch),
    .count (flush_cnt)
  );

endmodule
